model_nexys_pruned_5_div_seq_21s_8s: RTL

MODEL_NEXYS_PRUNED_5_DIV_SEQ_21S_8S -- requirements
Module: model_nexys_pruned_5_div_seq_21s_8s

---
 rtl/model_nexys_pruned_5_div_seq_21s_8s.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/model_nexys_pruned_5_div_seq_21s_8s.sv
// Sequential 21s/8s restoring divider: 21 shift-subtract steps, one sign step, saturating 13-bit quotient.
// Build option DIV_SEQ_REM_OUT_EN drives the signed remainder on rem; without it rem is tied to zero.
module model_nexys_pruned_5_div_seq_21s_8s #(
    parameter logic [31:0] ID = 32'd1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    // Handshakes: a transfer happens on a rising edge where ce, valid and ready are all high.
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [20:0] dividend,
    input  logic signed [7:0]  divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [12:0]        quot,
    output logic signed [7:0]  rem,
    output logic               sat,
    output logic               dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [12:0] QUOT_MAX = 13'd8191;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [20:0] mag_q;      // dividend magnitude, shifted out while quotient bits shift in
    logic [7:0]  dvs_q;      // divisor magnitude, 128 representable
    logic [8:0]  part_q;     // partial remainder
    logic        neg_n_q;
    logic        neg_d_q;
    logic        out_valid_q;
    logic [12:0] quot_q;
    logic        sat_q;
    logic        dz_q;

    logic [8:0]  part_sh;
    logic        sub_ok;
    logic [8:0]  part_d;
    logic [20:0] mag_d;
    logic        q_neg;
    logic        unused_id;

    assign unused_id = ^ID;

    assign part_sh = {part_q[7:0], mag_q[20]};
    assign sub_ok  = (part_sh >= {1'b0, dvs_q});
    assign part_d  = sub_ok ? (part_sh - {1'b0, dvs_q}) : part_sh;
    assign mag_d   = {mag_q[19:0], sub_ok};
    assign q_neg   = neg_n_q ^ neg_d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            sat_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mag_q   <= dividend[20] ? 21'(-dividend) : dividend;
                        dvs_q   <= divisor[7] ? 8'(-divisor) : divisor;
                        neg_n_q <= dividend[20];
                        neg_d_q <= divisor[7];
                        part_q  <= '0;
                        cnt_q   <= 5'd21;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    mag_q  <= mag_d;
                    part_q <= part_d;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    // Any nonzero negative quotient is below the unsigned range.
                    if (dvs_q == 8'd0) begin
                        quot_q <= QUOT_MAX;
                        sat_q  <= 1'b0;
                        dz_q   <= 1'b1;
                    end else if (q_neg && (mag_q != 21'd0)) begin
                        quot_q <= '0;
                        sat_q  <= 1'b1;
                        dz_q   <= 1'b0;
                    end else if (mag_q > 21'(QUOT_MAX)) begin
                        quot_q <= QUOT_MAX;
                        sat_q  <= 1'b1;
                        dz_q   <= 1'b0;
                    end else begin
                        quot_q <= mag_q[12:0];
                        sat_q  <= 1'b0;
                        dz_q   <= 1'b0;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DIV_SEQ_REM_OUT_EN
    logic signed [7:0] rem_q;

    // Remainder magnitude is below the divisor magnitude, so it fits in 7 bits plus sign.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
        end else if (ce && (state_q == S_SIGN)) begin
            if (dvs_q == 8'd0) begin
                rem_q <= '0;
            end else if (neg_n_q) begin
                rem_q <= 8'(-part_q[7:0]);
            end else begin
                rem_q <= part_q[7:0];
            end
        end
    end

    assign rem = rem_q;
`else
    assign rem = '0;
`endif

    assign in_ready  = ce & (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign sat       = sat_q;
    assign dz        = dz_q;

endmodule
